// File: rtl/pipe_pkg.sv
// pipe_pkg: shared stage payload widths, nop encoding and occupancy encoding
// for the 5-stage MIPS pipeline registers.
package pipe_pkg;
    localparam int IF_ID_W  = 96;
    localparam int ID_EX_W  = 160;
    localparam int EX_MEM_W = 106;
    localparam int MEM_WB_W = 71;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;
endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with stall, flush and
// an optional skid entry that makes in_ready depend on flops only.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W = IF_ID_W,
    parameter bit                SKID   = 1'b1,
    parameter logic [DATA_W-1:0] BUBBLE = '0
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_data,
    input  logic              i_stall,
    input  logic              i_flush,
    output logic [1:0]        o_occupancy
);
    logic              r_main_v;
    logic [DATA_W-1:0] r_main;
    logic              w_skid_v;
    logic [DATA_W-1:0] w_skid;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_drain_skid;
    logic              w_load_skid;
    logic              w_main_v_nxt;
    logic [DATA_W-1:0] w_main_nxt;
    occ_e              w_occ;

    assign w_occ        = occ_e'({1'b0, r_main_v} + {1'b0, w_skid_v});
    assign w_out_fire   = r_main_v & i_out_ready & ~i_stall;
    assign o_in_ready   = SKID ? (w_occ != OCC_TWO) : (~r_main_v | (i_out_ready & ~i_stall));
    assign w_in_fire    = i_in_valid & o_in_ready;
    assign w_drain_skid = w_skid_v & w_out_fire;
    // A beat arriving while the main entry stays occupied parks in the skid entry.
    assign w_load_skid  = w_in_fire & r_main_v & ~w_out_fire;
    assign o_out_valid  = r_main_v;
    assign o_out_data   = r_main;
    assign o_occupancy  = w_occ;

    always_comb begin
        w_main_v_nxt = r_main_v;
        w_main_nxt   = r_main;
        if (i_flush) begin
            w_main_v_nxt = 1'b0;
            w_main_nxt   = BUBBLE;
        end else if (w_drain_skid) begin
            w_main_nxt   = w_skid;
        end else if (w_in_fire && !w_load_skid) begin
            w_main_v_nxt = 1'b1;
            w_main_nxt   = i_in_data;
        end else if (w_out_fire) begin
            w_main_v_nxt = 1'b0;
            w_main_nxt   = BUBBLE;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_main_v <= 1'b0;
            r_main   <= BUBBLE;
        end else begin
            r_main_v <= w_main_v_nxt;
            r_main   <= w_main_nxt;
        end
    end

    generate
        if (SKID) begin : g_skid
            logic              r_skid_v;
            logic [DATA_W-1:0] r_skid;
            always_ff @(posedge i_clk or negedge i_reset_n) begin
                if (!i_reset_n) begin
                    r_skid_v <= 1'b0;
                    r_skid   <= BUBBLE;
                end else if (i_flush) begin
                    r_skid_v <= 1'b0;
                end else if (w_load_skid) begin
                    r_skid_v <= 1'b1;
                    r_skid   <= i_in_data;
                end else if (w_drain_skid) begin
                    r_skid_v <= 1'b0;
                end
            end
            assign w_skid_v = r_skid_v;
            assign w_skid   = r_skid;
        end else begin : g_no_skid
            assign w_skid_v = 1'b0;
            assign w_skid   = BUBBLE;
        end
    endgenerate
endmodule
